// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save stream accumulator.
// Build macro CSA_SIGNED_EN selects two's-complement operand extension.
package csa_pkg;

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        CPA  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int EXT_MAX_W = 64;

    // Extends the low 'width' bits of data to EXT_MAX_W bits; caller truncates to its width.
    function automatic logic [EXT_MAX_W-1:0] ext_operand(input logic [EXT_MAX_W-1:0] data,
                                                         input int width);
        logic [EXT_MAX_W-1:0] r;
        logic                 fill;
`ifdef CSA_SIGNED_EN
        fill = data[6'(width - 1)];
`else
        fill = 1'b0;
`endif
        r = '0;
        for (int i = 0; i < EXT_MAX_W; i++) begin
            if (i < width) begin
                r[i] = data[i];
            end else begin
                r[i] = fill;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/csa_stream_accumulator_compress.sv
// Bitwise 3:2 full-adder row; the carry vector is returned unshifted.
module csa_compress_3to2 #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    output logic [N-1:0] s,
    output logic [N-1:0] cy
);

    assign s  = a ^ b ^ c;
    assign cy = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand accumulator holding the running total in sum/carry form.
// Build macro CSA_SIGNED_EN: sign-extend operands (two's-complement result).
module csa_stream_accumulator
    import csa_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_OPS = 16,
    localparam int CNT_W  = $clog2(MAX_OPS) + 1,
    localparam int OUT_W  = WIDTH + $clog2(MAX_OPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    state_t             state_r;
    state_t             next_state_s;
    logic [OUT_W-1:0]   s_r;
    logic [OUT_W-1:0]   c_r;
    logic [CNT_W-1:0]   count_r;
    logic               ovf_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [OUT_W-1:0]   out_sum_r;
    logic [CNT_W-1:0]   out_count_r;
    logic               out_ovf_r;
    logic [OUT_W-1:0]   operand_s;
    logic [OUT_W-1:0]   s3_s;
    logic [OUT_W-1:0]   c3_s;
    logic [OUT_W-1:0]   c_shift_s;
    logic               beat_s;
    logic               at_max_s;

    assign beat_s    = in_valid & in_ready_r;
    assign at_max_s  = (count_r == CNT_W'(MAX_OPS));
    assign operand_s = OUT_W'(ext_operand(EXT_MAX_W'(in_data), WIDTH));
    assign c_shift_s = OUT_W'({c3_s, 1'b0});

    csa_compress_3to2 #(
        .N (OUT_W)
    ) u_compress (
        .a  (s_r),
        .b  (c_r),
        .c  (operand_s),
        .s  (s3_s),
        .cy (c3_s)
    );

    // Next-state decode for the accumulate / final-add / hold sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ACC: begin
                if (beat_s && in_last) begin
                    next_state_s = CPA;
                end else begin
                    next_state_s = ACC;
                end
            end
            CPA: begin
                next_state_s = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    next_state_s = ACC;
                end else begin
                    next_state_s = HOLD;
                end
            end
            default: begin
                next_state_s = ACC;
            end
        endcase
    end

    // State register; in_ready is registered so it stays low while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ACC;
            in_ready_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            in_ready_r <= (next_state_s == ACC);
        end
    end

    // Redundant accumulator, operand counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r         <= '0;
            c_r         <= '0;
            count_r     <= '0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_sum_r   <= '0;
            out_count_r <= '0;
            out_ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ACC: begin
                    if (beat_s) begin
                        s_r <= s3_s;
                        c_r <= c_shift_s;
                        if (at_max_s) begin
                            ovf_r <= 1'b1;
                        end else begin
                            count_r <= count_r + CNT_W'(1);
                        end
                    end
                end
                CPA: begin
                    out_sum_r   <= s_r + c_r;
                    out_count_r <= count_r;
                    out_ovf_r   <= ovf_r;
                    out_valid_r <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        s_r         <= '0;
                        c_r         <= '0;
                        count_r     <= '0;
                        ovf_r       <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign out_count = out_count_r;
    assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed self-checking bench for csa_stream_accumulator (default parameters).
module tb_csa_stream_accumulator;

    localparam int WIDTH = 4;
    localparam int CNT_W = 5;
    localparam int OUT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    int tests_run;
    int tests_failed;

    csa_stream_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one beat, waits for the accepting edge, then samples 1 time unit later.
    task automatic send_beat(input logic [WIDTH-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 4'h0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #12;
        tests_run++;
        if ({out_valid, out_sum, out_count, out_ovf} !== 15'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b sum=%0d cnt=%0d ovf=%b, want all 0",
                     out_valid, out_sum, out_count, out_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_beat(4'd11, 1'b0);
        send_beat(4'd2, 1'b0);
        send_beat(4'd4, 1'b0);
        send_beat(4'd7, 1'b1);
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_early: got v=%b rdy=%b, want v=0 rdy=0", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_sum !== 8'd24 || out_count !== 5'd4 || out_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_result: got v=%b sum=%0d cnt=%0d ovf=%b, want v=1 sum=24 cnt=4 ovf=0",
                     out_valid, out_sum, out_count, out_ovf);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_release: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_beat(4'd15, (i == 3) ? 1'b1 : 1'b0);
        end
        wait_valid(ok);
        tests_run++;
        if (!ok || out_sum !== 8'd60 || out_count !== 5'd4 || out_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_full: got ok=%b sum=%0d cnt=%0d ovf=%b, want ok=1 sum=60 cnt=4 ovf=0",
                     ok, out_sum, out_count, out_ovf);
        end
        @(posedge clk);
        #1;
        send_beat(4'd10, 1'b1);
        wait_valid(ok);
        tests_run++;
        if (!ok || out_sum !== 8'd10 || out_count !== 5'd1 || out_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_single: got ok=%b sum=%0d cnt=%0d ovf=%b, want ok=1 sum=10 cnt=1 ovf=0",
                     ok, out_sum, out_count, out_ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        out_ready = 1'b0;
        send_beat(4'd12, 1'b0);
        send_beat(4'd5, 1'b0);
        send_beat(4'd10, 1'b0);
        send_beat(4'd10, 1'b1);
        wait_valid(ok);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || out_sum !== 8'd37 || out_count !== 5'd4 || in_ready !== 1'b0) begin
                bad++;
            end
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (!ok || bad != 0) begin
            tests_failed++;
            $display("FAIL bp_hold: got ok=%b bad_cycles=%0d sum=%0d rdy=%b, want ok=1 bad=0 sum=37 rdy=0",
                     ok, bad, out_sum, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send_beat(4'd15, (i == 19) ? 1'b1 : 1'b0);
        end
        wait_valid(ok);
        tests_run++;
        if (!ok || out_sum !== 8'd44 || out_count !== 5'd16 || out_ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_result: got ok=%b sum=%0d cnt=%0d ovf=%b, want ok=1 sum=44 cnt=16 ovf=1",
                     ok, out_sum, out_count, out_ovf);
        end
        @(posedge clk);
        #1;
        send_beat(4'd1, 1'b0);
        send_beat(4'd1, 1'b1);
        wait_valid(ok);
        tests_run++;
        if (!ok || out_sum !== 8'd2 || out_count !== 5'd2 || out_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_next: got ok=%b sum=%0d cnt=%0d ovf=%b, want ok=1 sum=2 cnt=2 ovf=0",
                     ok, out_sum, out_count, out_ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        out_ready = 1'b1;
        send_beat(4'd9, 1'b0);
        send_beat(4'd9, 1'b0);
        send_beat(4'd9, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, out_sum, out_count, out_ovf} !== 15'd0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got v=%b sum=%0d cnt=%0d ovf=%b rdy=%b, want all 0",
                     out_valid, out_sum, out_count, out_ovf, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_beat(4'd7, 1'b0);
        send_beat(4'd6, 1'b0);
        send_beat(4'd12, 1'b0);
        send_beat(4'd8, 1'b1);
        wait_valid(ok);
        tests_run++;
        if (!ok || out_sum !== 8'd33 || out_count !== 5'd4 || out_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_next: got ok=%b sum=%0d cnt=%0d ovf=%b, want ok=1 sum=33 cnt=4 ovf=0",
                     ok, out_sum, out_count, out_ovf);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef CSA_SIGNED_EN
    task automatic test_signed();
        bit ok;
        out_ready = 1'b1;
        send_beat(4'hD, 1'b0);
        send_beat(4'h5, 1'b0);
        send_beat(4'h8, 1'b1);
        wait_valid(ok);
        tests_run++;
        if (!ok || out_sum !== 8'hFA || out_count !== 5'd3 || out_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL signed_sum: got ok=%b sum=%h cnt=%0d ovf=%b, want ok=1 sum=fa cnt=3 ovf=0",
                     ok, out_sum, out_count, out_ovf);
        end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
`ifdef CSA_SIGNED_EN
        test_signed();
        test_reset_mid_packet();
`else
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_mid_packet();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
